nibble_add_seq: RTL and testbench

Multi-precision add/subtract sequencer that reuses a single 4-bit ripple-carry adder over several cycles. Operands `4*NIBBLES` bits wide are accepted through a valid/ready handshake. The block steps the adder LSB-nibble first, one nibble per clock, and chains the carry through a register. It sits between the arithmetic control path and the team's 4-bit adder datapath, giving wide arithmetic without widening the adder.

---
 rtl/nibble_add_seq_if.sv | 29 ++
 rtl/nibble_add_seq.sv | 94 +++++++++
 tb/tb_nibble_add_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Request/response bundle for the nibble-serial add/subtract sequencer.
// The master issues operations; the slave (the sequencer) returns results.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         done;
  logic         busy;

  modport master (
    output start_valid, a, b, cin, sub,
    input  start_ready, result, cout, overflow, done, busy
  );

  modport slave (
    input  start_valid, a, b, cin, sub,
    output start_ready, result, cout, overflow, done, busy
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Wide add/subtract built from one 4-bit adder stepped LSB nibble first,
// with the carry chained through a register between cycles.
//
// state | meaning
// IDLE  | ready for a request; outputs hold the last completed result
// RUN   | one nibble per clock, idx_q selects the slice
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    work_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            overflow_q;
  logic            done_q;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [4:0]      sum;
  logic [W-1:0]    slice_mask;
  logic [W-1:0]    work_d;
  logic            last;

  assign nib_a      = 4'(opa_q >> {idx_q, 2'b00});
  assign nib_b      = 4'(opb_q >> {idx_q, 2'b00});
  assign sum        = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
  assign slice_mask = W'(4'hF) << {idx_q, 2'b00};
  assign work_d     = (work_q & ~slice_mask) | (W'(sum[3:0]) << {idx_q, 2'b00});
  assign last       = (idx_q == IDXW'(NIBBLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      work_q     <= '0;
      carry_q    <= 1'b0;
      idx_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b ^ {W{bus.sub}};
            carry_q <= bus.sub | bus.cin;
            idx_q   <= '0;
            work_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          work_q  <= work_d;
          carry_q <= sum[4];
          if (last) begin
            // Outputs move only here so they never expose partial sums.
            result_q   <= work_d;
            cout_q     <= sum[4];
            overflow_q <= (opa_q[W-1] == opb_q[W-1]) && (work_d[W-1] != opa_q[W-1]);
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q == RUN);
  assign bus.result      = result_q;
  assign bus.cout        = cout_q;
  assign bus.overflow    = overflow_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed and randomized checks of nibble_add_seq at NIBBLES = 4, 1 and 8,
// with expected values computed in the bench.
module tb_nibble_add_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  valid = 3'b000;
  logic [31:0] tb_a = '0;
  logic [31:0] tb_b = '0;
  logic        tb_cin = 1'b0;
  logic        tb_sub = 1'b0;

  int total = 0;
  int bad = 0;

  localparam int NIB [3] = '{4, 1, 8};

  always #5 clk = ~clk;

  nibble_add_seq_if #(.NIBBLES(4)) if0 ();
  nibble_add_seq_if #(.NIBBLES(1)) if1 ();
  nibble_add_seq_if #(.NIBBLES(8)) if2 ();

  nibble_add_seq #(.NIBBLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  nibble_add_seq #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  nibble_add_seq #(.NIBBLES(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start_valid = valid[0];
  assign if0.a = tb_a[15:0];
  assign if0.b = tb_b[15:0];
  assign if0.cin = tb_cin;
  assign if0.sub = tb_sub;
  assign if1.start_valid = valid[1];
  assign if1.a = tb_a[3:0];
  assign if1.b = tb_b[3:0];
  assign if1.cin = tb_cin;
  assign if1.sub = tb_sub;
  assign if2.start_valid = valid[2];
  assign if2.a = tb_a;
  assign if2.b = tb_b;
  assign if2.cin = tb_cin;
  assign if2.sub = tb_sub;

  logic [31:0] obs_res [3];
  logic        obs_cout [3];
  logic        obs_ov [3];
  logic        obs_done [3];
  logic        obs_busy [3];
  logic        obs_rdy [3];

  assign obs_res[0] = 32'(if0.result);
  assign obs_res[1] = 32'(if1.result);
  assign obs_res[2] = if2.result;
  assign obs_cout[0] = if0.cout;
  assign obs_cout[1] = if1.cout;
  assign obs_cout[2] = if2.cout;
  assign obs_ov[0] = if0.overflow;
  assign obs_ov[1] = if1.overflow;
  assign obs_ov[2] = if2.overflow;
  assign obs_done[0] = if0.done;
  assign obs_done[1] = if1.done;
  assign obs_done[2] = if2.done;
  assign obs_busy[0] = if0.busy;
  assign obs_busy[1] = if1.busy;
  assign obs_busy[2] = if2.busy;
  assign obs_rdy[0] = if0.start_ready;
  assign obs_rdy[1] = if1.start_ready;
  assign obs_rdy[2] = if2.start_ready;

  logic [31:0] last_res [3] = '{32'h0, 32'h0, 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {overflow, cout, result} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] m, aa, bb, s;
    logic [31:0] res;
    logic        co, ov, sa, sb, sr;
    m  = (64'h1 << w) - 64'h1;
    aa = {32'h0, a} & m;
    bb = {32'h0, b} & m;
    if (sub) begin
      s  = aa - bb;
      co = (aa >= bb);
    end else begin
      s  = aa + bb + {63'h0, cin};
      co = s[w];
    end
    res = s[31:0] & m[31:0];
    sa  = aa[w-1];
    sb  = bb[w-1];
    sr  = res[w-1];
    ov  = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, co, res};
  endfunction

  task automatic run_op(input int k, input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] er,
                        input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub;
    valid[k] = 1'b1;
    chk({tag, "_ready_idle"}, 32'(obs_rdy[k]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0;
    tb_a = $urandom; tb_b = $urandom; tb_cin = 1'($urandom); tb_sub = 1'($urandom);
    lat = 0;
    while (obs_done[k] !== 1'b1 && lat < 20) begin
      chk({tag, "_busy"}, 32'(obs_busy[k]), 32'h1);
      chk({tag, "_ready_low"}, 32'(obs_rdy[k]), 32'h0);
      chk({tag, "_hold"}, obs_res[k], last_res[k]);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(NIB[k]));
    chk({tag, "_done"}, 32'(obs_done[k]), 32'h1);
    chk({tag, "_result"}, obs_res[k], er);
    chk({tag, "_cout"}, 32'(obs_cout[k]), 32'(ec));
    chk({tag, "_ovf"}, 32'(obs_ov[k]), 32'(eo));
    chk({tag, "_ready_done"}, 32'(obs_rdy[k]), 32'h1);
    chk({tag, "_busy_done"}, 32'(obs_busy[k]), 32'h0);
    last_res[k] = er;
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(obs_done[k]), 32'h0);
    chk({tag, "_result_held"}, obs_res[k], er);
  endtask

  initial begin
    logic [33:0] q [$];
    logic [33:0] e;
    int          last_acc;
    logic        exp_rdy, exp_done;

    // Reset values while rst_n is low
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(obs_rdy[k]), 32'h1);
      chk("rst_busy", 32'(obs_busy[k]), 32'h0);
      chk("rst_done", 32'(obs_done[k]), 32'h0);
      chk("rst_result", obs_res[k], 32'h0);
      chk("rst_cout", 32'(obs_cout[k]), 32'h0);
      chk("rst_ovf", 32'(obs_ov[k]), 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed NIBBLES=4 vectors
    run_op(0, "add_carry", 32'h1234, 32'h0FCD, 1'b0, 1'b0, 32'h2201, 1'b0, 1'b0);
    run_op(0, "ripple", 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
    run_op(0, "add_ovf", 32'h7FFF, 32'h0000, 1'b1, 1'b0, 32'h8000, 1'b0, 1'b1);
    run_op(0, "sub_neg", 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    run_op(0, "sub_ovf", 32'h8000, 32'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1);

    // Back-to-back: start_valid held high, operands change every cycle
    last_acc = -100;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      valid[0] = (c < 26);
      tb_a = 32'($urandom_range(0, 16'hFFFF));
      tb_b = 32'($urandom_range(0, 16'hFFFF));
      tb_cin = 1'(c);
      tb_sub = 1'(c >> 1);
      exp_rdy  = ((c - last_acc) >= 5);
      exp_done = ((c - last_acc) == 5);
      chk("hs_ready", 32'(obs_rdy[0]), 32'(exp_rdy));
      chk("hs_busy", 32'(obs_busy[0]), 32'(!exp_rdy));
      chk("hs_done", 32'(obs_done[0]), 32'(exp_done));
      if (exp_done) begin
        e = q.pop_front();
        chk("hs_result", obs_res[0], e[31:0]);
        chk("hs_cout", 32'(obs_cout[0]), 32'(e[32]));
        chk("hs_ovf", 32'(obs_ov[0]), 32'(e[33]));
        last_res[0] = e[31:0];
      end
      if (exp_rdy && valid[0]) begin
        q.push_back(model(16, tb_a, tb_b, tb_cin, tb_sub));
        last_acc = c;
      end
    end
    valid[0] = 1'b0;
    chk("hs_drained", 32'(q.size()), 32'h0);

    // Reset in the middle of a run
    run_op(0, "pre_rst", 32'h1234, 32'h0FCD, 1'b0, 1'b0, 32'h2201, 1'b0, 1'b0);
    @(negedge clk);
    tb_a = 32'h1234; tb_b = 32'h0FCD; tb_cin = 1'b0; tb_sub = 1'b0;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", obs_res[0], 32'h0);
    chk("mid_rst_busy", 32'(obs_busy[0]), 32'h0);
    chk("mid_rst_ready", 32'(obs_rdy[0]), 32'h1);
    chk("mid_rst_done", 32'(obs_done[0]), 32'h0);
    chk("mid_rst_cout", 32'(obs_cout[0]), 32'h0);
    last_res = '{32'h0, 32'h0, 32'h0};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(obs_done[0]), 32'h0);
    end
    run_op(0, "post_rst", 32'h0001, 32'h0001, 1'b0, 1'b0, 32'h0002, 1'b0, 1'b0);

    // NIBBLES=1 and NIBBLES=8
    run_op(1, "n1_sub_ovf", 32'h8, 32'h1, 1'b0, 1'b1, 32'h7, 1'b1, 1'b1);
    run_op(2, "n8_ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      e = model(4, ra, rb, rc, rs);
      run_op(1, "n1_rand", ra, rb, rc, rs, e[31:0], e[32], e[33]);
      e = model(32, ra, rb, rc, rs);
      run_op(2, "n8_rand", ra, rb, rc, rs, e[31:0], e[32], e[33]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
